// File: rtl/avalon_sysctrl_capture_writer.sv
// Circular-buffer debug capture writer for the avalon_sysctrl 256x32 RAM (s1 port).
// Optional CAPTURE_TSTAMP_EN puts an 8-bit timestamp in writedata[31:24].
module avalon_sysctrl_capture_writer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int POST_TRIG = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_clken,
  output logic [1:0]        st_state,
  output logic              st_wrap,
  output logic [ADDR_W-1:0] st_trig_addr,
  output logic [ADDR_W-1:0] st_last_addr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] POST_N = ADDR_W'(POST_TRIG);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] cnt;
  logic              trig_pend;
  logic              acc;
  logic              trig_beat;
  logic [DATA_W-1:0] wdata;

  assign acc      = in_valid & in_ready;
  assign st_state = state;
  // trig with no beat leaves a pending trigger for the next accepted beat
  assign trig_beat = ((state == S_PRE) & trig) | trig_pend;

`ifdef CAPTURE_TSTAMP_EN
  logic [7:0] tstamp;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tstamp <= '0;
    end else if (arm) begin
      tstamp <= '0;
    end else begin
      tstamp <= tstamp + 8'd1;
    end
  end

  assign wdata = {tstamp, in_data[23:0]};
`else
  assign wdata = in_data;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      cnt          <= '0;
      trig_pend    <= 1'b0;
      in_ready     <= 1'b0;
      m_clken      <= 1'b0;
      m_address    <= '0;
      m_byteenable <= '0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      st_wrap      <= 1'b0;
      st_trig_addr <= '0;
      st_last_addr <= '0;
    end else begin
      in_ready     <= 1'b1;
      m_clken      <= 1'b1;
      m_write      <= 1'b0;
      m_chipselect <= 1'b0;
      m_byteenable <= '0;
      if (abort) begin
        state <= S_IDLE;
      end else if (arm) begin
        state     <= S_PRE;
        wr_ptr    <= '0;
        st_wrap   <= 1'b0;
        trig_pend <= 1'b0;
      end else if (state == S_PRE || state == S_POST) begin
        if (state == S_PRE && trig && !acc) begin
          trig_pend <= 1'b1;
          state     <= S_POST;
        end
        if (acc) begin
          m_write      <= 1'b1;
          m_chipselect <= 1'b1;
          m_byteenable <= 4'hF;
          m_address    <= wr_ptr;
          m_writedata  <= wdata;
          st_last_addr <= wr_ptr;
          wr_ptr       <= wr_ptr + 1'b1;
          if (&wr_ptr) st_wrap <= 1'b1;
          if (trig_beat) begin
            trig_pend    <= 1'b0;
            st_trig_addr <= wr_ptr;
            cnt          <= POST_N;
            state        <= (POST_TRIG == 0) ? S_DONE : S_POST;
          end else if (state == S_POST) begin
            cnt <= cnt - 1'b1;
            if (cnt == ADDR_W'(1)) state <= S_DONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_sysctrl_capture_writer.sv
// Bench: two capture writers (POST_TRIG 4 and 0) checked against a beat-count model.
// Directed scenarios with literal pins, then randomized traffic.
module tb_avalon_sysctrl_capture_writer;

  localparam int P0 = 4;
  localparam int P1 = 0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trig = 1'b0;

  logic        rdy [2];
  logic        cs [2];
  logic        wr [2];
  logic        clken [2];
  logic        wrap [2];
  logic [7:0]  addr [2];
  logic [7:0]  taddr [2];
  logic [7:0]  laddr [2];
  logic [3:0]  be [2];
  logic [31:0] wdat [2];
  logic [1:0]  st [2];

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  avalon_sysctrl_capture_writer #(.POST_TRIG(P0)) u0 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy[0]), .arm(arm),
    .abort(abort), .trig(trig), .m_address(addr[0]),
    .m_byteenable(be[0]), .m_chipselect(cs[0]),
    .m_write(wr[0]), .m_writedata(wdat[0]),
    .m_clken(clken[0]), .st_state(st[0]),
    .st_wrap(wrap[0]), .st_trig_addr(taddr[0]),
    .st_last_addr(laddr[0])
  );

  avalon_sysctrl_capture_writer #(.POST_TRIG(P1)) u1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy[1]), .arm(arm),
    .abort(abort), .trig(trig), .m_address(addr[1]),
    .m_byteenable(be[1]), .m_chipselect(cs[1]),
    .m_write(wr[1]), .m_writedata(wdat[1]),
    .m_clken(clken[1]), .st_state(st[1]),
    .st_wrap(wrap[1]), .st_trig_addr(taddr[1]),
    .st_last_addr(laddr[1])
  );

  // model: beats counted since arm; address = count mod 256
  int          n [2];
  int          tidx [2];
  bit          tarm [2];
  bit          ht [2];
  logic        e_rdy [2];
  logic        e_clken [2];
  logic        e_wr [2];
  logic [7:0]  e_addr [2];
  logic [31:0] e_dat [2];
  logic [7:0]  e_taddr [2];
  logic [7:0]  e_laddr [2];
  logic [1:0]  e_st [2];
  int          ts = 0;

  function automatic int pt(input int i);
    return (i == 0) ? P0 : P1;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s[%0d] got %h want %h at %0t", nm, i, a, e, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [31:0] d;
`ifdef CAPTURE_TSTAMP_EN
    d = {ts[7:0], in_data[23:0]};
`else
    d = in_data;
`endif
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        n[i] = 0; tidx[i] = 0; tarm[i] = 0; ht[i] = 0;
        e_rdy[i] = 0; e_clken[i] = 0; e_wr[i] = 0;
        e_addr[i] = 0; e_dat[i] = 0; e_taddr[i] = 0;
        e_laddr[i] = 0; e_st[i] = 0;
      end else begin
        bit acc;
        acc = in_valid && e_rdy[i];
        e_rdy[i] = 1; e_clken[i] = 1; e_wr[i] = 0;
        if (abort) e_st[i] = 0;
        else if (arm) begin
          e_st[i] = 1; n[i] = 0; tarm[i] = 0; ht[i] = 0;
        end else if (e_st[i] == 1 || e_st[i] == 2) begin
          if (e_st[i] == 1 && trig) begin
            tarm[i] = 1; e_st[i] = 2;
          end
          if (acc) begin
            e_wr[i] = 1;
            e_addr[i] = 8'(n[i] % 256);
            e_dat[i] = d;
            e_laddr[i] = e_addr[i];
            n[i]++;
            if (tarm[i] && !ht[i]) begin
              ht[i] = 1; tidx[i] = n[i] - 1; e_taddr[i] = e_addr[i];
            end
            if (ht[i] && (n[i] - 1 - tidx[i]) == pt(i)) e_st[i] = 3;
          end
        end
      end
    end
    if (!reset_n || arm) ts = 0;
    else ts++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("in_ready", i, 32'(rdy[i]), 32'(e_rdy[i]));
        chk("m_clken", i, 32'(clken[i]), 32'(e_clken[i]));
        chk("m_write", i, 32'(wr[i]), 32'(e_wr[i]));
        chk("m_chipselect", i, 32'(cs[i]), 32'(e_wr[i]));
        chk("m_byteenable", i, 32'(be[i]), e_wr[i] ? 32'hF : 32'h0);
        chk("st_state", i, 32'(st[i]), 32'(e_st[i]));
        chk("st_wrap", i, 32'(wrap[i]), 32'(n[i] >= 256));
        chk("st_trig_addr", i, 32'(taddr[i]), 32'(e_taddr[i]));
        chk("st_last_addr", i, 32'(laddr[i]), 32'(e_laddr[i]));
        if (e_wr[i]) begin
          chk("m_address", i, 32'(addr[i]), 32'(e_addr[i]));
          chk("m_writedata", i, wdat[i], e_dat[i]);
        end
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] d,
                      input bit a = 0, input bit ab = 0, input bit t = 0);
    in_valid = v; in_data = d; arm = a; abort = ab; trig = t;
    @(posedge clk);
    #1;
    in_valid = 0; arm = 0; abort = 0; trig = 0;
  endtask

  initial begin
    reset_n = 0;
    for (int k = 0; k < 3; k++) begin
      step(1, 32'hDEAD0000 + 32'(k));
      chk_en = 1;
      chk("rst_write", 0, 32'(wr[0]), 32'h0);
      chk("rst_clken", 0, 32'(clken[0]), 32'h0);
    end
    reset_n = 1;
    step(1, 32'h1234);
    chk("rel_clken", 0, 32'(clken[0]), 32'h1);
    chk("rel_ready", 1, 32'(rdy[1]), 32'h1);

    step(0, 0, 1);
    for (int k = 0; k < 10; k++) step(1, 32'h100 + 32'(k), 0, 0, k == 5);
    chk("t2_state", 0, 32'(st[0]), 32'd3);
    chk("t2_trig", 0, 32'(taddr[0]), 32'd5);
    chk("t2_last", 0, 32'(laddr[0]), 32'd9);
    chk("t2_wrap", 0, 32'(wrap[0]), 32'd0);
    chk("t2_state", 1, 32'(st[1]), 32'd3);
    chk("t2_last", 1, 32'(laddr[1]), 32'd5);

    step(0, 0, 1);
    for (int k = 0; k < 300; k++) begin
      step(1, $urandom);
      if (k == 254) chk("t3_nowrap", 0, 32'(wrap[0]), 32'd0);
      if (k == 255) chk("t3_wrap", 0, 32'(wrap[0]), 32'd1);
    end
    chk("t3_state", 0, 32'(st[0]), 32'd1);
    chk("t3_last", 0, 32'(laddr[0]), 32'd43);

    step(1, 32'h11, 1, 0, 1);
    chk("t4_armtrig", 0, 32'(st[0]), 32'd1);
    for (int k = 0; k < 3; k++) step(1, 32'h20 + 32'(k));
    step(1, 32'h55, 0, 0, 1);
    chk("t4_post", 0, 32'(st[0]), 32'd2);
    step(1, 32'h66);
    step(1, 32'h77, 0, 1);
    chk("t4_abort", 0, 32'(st[0]), 32'd0);
    chk("t4_last", 0, 32'(laddr[0]), 32'd4);
    for (int k = 0; k < 3; k++) step(1, 32'h80 + 32'(k));
    chk("t4_nowrite", 0, 32'(wr[0]), 32'd0);

    step(0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0);
    step(1, 32'hABCD);
    chk("t5_write", 1, 32'(wr[1]), 32'd1);
`ifndef CAPTURE_TSTAMP_EN
    chk("t5_data", 1, wdat[1], 32'hABCD);
`endif
    chk("t5_state", 1, 32'(st[1]), 32'd3);
    chk("t5_trig", 1, 32'(taddr[1]), 32'd0);
    chk("t5_last", 1, 32'(laddr[1]), 32'd0);

    step(0, 0, 1);
    step(0, 0);
    step(1, 32'hAA123456);
    step(0, 0);
    step(0, 0);
    step(1, 32'hBB654321);
    step(0, 0);

    for (int k = 0; k < 4000; k++) begin
      reset_n = ($urandom_range(0, 999) != 0);
      step($urandom_range(0, 9) < 7, $urandom,
           $urandom_range(0, 199) == 0,
           $urandom_range(0, 399) == 0,
           $urandom_range(0, 49) == 0);
      reset_n = 1;
    end
    step(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
